// File: rtl/bcd_frac_to_bin_if.sv
// Handshake and data bundle for the BCD-fraction to binary-fraction converter.
// The master drives the start strobe and BCD operand; the slave returns the result.
interface bcd_frac_to_bin_if #(
    parameter int FRACTIONAL_BITS = 8,
    parameter int DECIMAL_DIGITS  = 7
);
    logic                          i_ce;
    logic [DECIMAL_DIGITS*4-1:0]   i_bcd;
    logic [FRACTIONAL_BITS-1:0]    o_bin;
    logic                          done;
    logic                          o_err;
    logic                          o_busy;

    modport master (
        output i_ce,
        output i_bcd,
        input  o_bin,
        input  done,
        input  o_err,
        input  o_busy
    );

    modport slave (
        input  i_ce,
        input  i_bcd,
        output o_bin,
        output done,
        output o_err,
        output o_busy
    );
endinterface

// File: rtl/bcd_frac_to_bin.sv
// Converts a D-digit BCD fraction to an F-bit binary fraction by decimal accumulation
// followed by restoring division by 10^D and round-half-up with saturation.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_ce; outputs hold last result
// S_ACCUM | folds one BCD digit per cycle into N, MSD first (D cycles)
// S_DIV   | one quotient bit per cycle, MSB first (F cycles)
// S_ROUND | rounds/saturates, registers o_bin/o_err, pulses done
module bcd_frac_to_bin #(
    parameter int FRACTIONAL_BITS = 8,
    parameter int DECIMAL_DIGITS  = 7
) (
    input  logic                CLK,
    input  logic                RST,
    bcd_frac_to_bin_if.slave    bus
);
    localparam int F = FRACTIONAL_BITS;
    localparam int D = DECIMAL_DIGITS;

    function automatic logic [63:0] pow10(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] POW10 = pow10(D);
    // N holds at most 10^D-1; R carries one extra bit so that 2R never overflows.
    localparam int NW = $clog2(POW10);
    localparam int RW = NW + 1;
    localparam logic [RW-1:0] DIVISOR = POW10[RW-1:0];

    localparam int CMAX = (D > F) ? D : F;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] ACC_LAST = CW'(D - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(F - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DIV   = 2'd2,
        S_ROUND = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [D*4-1:0]    bcd_q, bcd_d;
    logic [NW-1:0]     n_q, n_d;
    logic [RW-1:0]     r_q, r_d;
    logic [F-1:0]      q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [F-1:0]      obin_q, obin_d;
    logic              oerr_q, oerr_d;
    logic              done_q, done_d;

    logic [3:0]        digit;
    logic              digit_bad;
    logic [3:0]        digit_add;
    logic [RW-1:0]     r2;
    logic              r2_ge;
    logic [F:0]        q_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            n_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            obin_q  <= '0;
            oerr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            n_q     <= n_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            obin_q  <= obin_d;
            oerr_q  <= oerr_d;
            done_q  <= done_d;
        end
    end

    // Invalid nibbles contribute zero but are remembered in the sticky error flag.
    always_comb begin
        digit     = bcd_q[D*4-1 -: 4];
        digit_bad = (digit > 4'd9);
        digit_add = digit_bad ? 4'd0 : digit;
        r2        = {r_q[RW-2:0], 1'b0};
        r2_ge     = (r2 >= DIVISOR);
        q_inc     = {1'b0, q_q} + {{F{1'b0}}, r2_ge};
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        n_d     = n_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        obin_d  = obin_q;
        oerr_d  = oerr_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_ce) begin
                    bcd_d   = bus.i_bcd;
                    n_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                n_d   = n_q * NW'(10) + NW'(digit_add);
                err_d = err_q | digit_bad;
                bcd_d = bcd_q << 4;
                if (cnt_q == ACC_LAST) begin
                    cnt_d   = '0;
                    r_d     = {1'b0, n_d};
                    q_d     = '0;
                    state_d = S_DIV;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DIV: begin
                q_d = (q_q << 1) | F'(r2_ge);
                r_d = r2_ge ? (r2 - DIVISOR) : r2;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_ROUND: begin
                if (err_q) begin
                    obin_d = '0;
                end else if (q_inc[F]) begin
                    obin_d = '1;
                end else begin
                    obin_d = q_inc[F-1:0];
                end
                oerr_d  = err_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_bin  = obin_q;
    assign bus.o_err  = oerr_q;
    assign bus.done   = done_q;
    assign bus.o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_frac_to_bin.sv
// Randomized and directed bench for bcd_frac_to_bin against an arithmetic reference
// (place-value sum, scaled by 2^F / 10^D, rounded half up, saturated).
module tb_bcd_frac_to_bin;
    localparam int D   = 7;
    localparam int F   = 8;
    localparam int LAT = D + F + 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    bcd_frac_to_bin_if #(.FRACTIONAL_BITS(F), .DECIMAL_DIGITS(D)) bus ();

    bcd_frac_to_bin #(.FRACTIONAL_BITS(F), .DECIMAL_DIGITS(D)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [D*4-1:0] bcd, output logic [F-1:0] eb,
                                  output logic ee);
        longint n = 0;
        longint p = 1;
        longint s;
        int     dig;
        ee = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            dig = int'(bcd[i*4 +: 4]);
            if (dig > 9) begin
                ee  = 1'b1;
                dig = 0;
            end
            n = n * 10 + dig;
            p = p * 10;
        end
        s = (n * (longint'(1) << (F + 1)) + p) / (2 * p);
        if (s > (longint'(1) << F) - 1) s = (longint'(1) << F) - 1;
        eb = ee ? '0 : F'(s);
    endfunction

    function automatic logic [D*4-1:0] frac_to_bcd(input int x);
        longint t;
        logic [D*4-1:0] b;
        t = longint'(x);
        for (int i = 0; i < D; i++) t = t * 10;
        t = t / (longint'(1) << F);
        b = '0;
        for (int k = 0; k < D; k++) begin
            b[k*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic run_conv(input logic [D*4-1:0] bcd, input string tag,
                            output logic [F-1:0] got_bin);
        logic [F-1:0] eb;
        logic         ee;
        int           lat;
        logic         seen;
        model(bcd, eb, ee);
        @(negedge CLK);
        bus.i_ce  = 1'b1;
        bus.i_bcd = bcd;
        @(posedge CLK);
        #1;
        bus.i_ce = 1'b0;
        check_val({tag, "/busy"}, 64'(bus.o_busy), 64'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < LAT + 10) begin
            @(posedge CLK);
            #1;
            lat++;
            seen = bus.done;
        end
        check_val({tag, "/latency"}, 64'(lat), 64'(LAT));
        check_val({tag, "/bin"}, 64'(bus.o_bin), 64'(eb));
        check_val({tag, "/err"}, 64'(bus.o_err), 64'(ee));
        got_bin = bus.o_bin;
        @(posedge CLK);
        #1;
        check_val({tag, "/pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.o_busy && k < 100) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check_val("idle_wait", 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [F-1:0]   got;
        logic [D*4-1:0] b;
        int             dn;
        int             t_done[$];
        int             cyc;

        bus.i_ce  = 1'b0;
        bus.i_bcd = '0;

        repeat (3) @(posedge CLK);
        #1;
        check_val("rst/bin", 64'(bus.o_bin), 64'd0);
        check_val("rst/done", 64'(bus.done), 64'd0);
        check_val("rst/err", 64'(bus.o_err), 64'd0);
        check_val("rst/busy", 64'(bus.o_busy), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_conv(28'h5000000, "half", got);    check_val("half_c", 64'(got), 64'h80);
        run_conv(28'h1000000, "tenth", got);   check_val("tenth_c", 64'(got), 64'h1A);
        run_conv(28'h2500000, "quarter", got); check_val("quarter_c", 64'(got), 64'h40);
        run_conv(28'h0039062, "tiny", got);    check_val("tiny_c", 64'(got), 64'h01);
        run_conv(28'h9999999, "sat", got);     check_val("sat_c", 64'(got), 64'hFF);
        run_conv(28'h0000000, "zero", got);    check_val("zero_c", 64'(got), 64'h00);
        run_conv(28'h3A00000, "bad", got);     check_val("bad_c", 64'(got), 64'h00);
        check_val("bad_err_c", 64'(bus.o_err), 64'd1);
        run_conv(28'h5000000, "recover", got); check_val("recover_err_c", 64'(bus.o_err), 64'd0);

        for (int x = 0; x < (1 << F); x++) begin
            run_conv(frac_to_bcd(x), "roundtrip", got);
            check_val("roundtrip_x", 64'(got), 64'(x));
        end

        for (int v = 0; v < 150; v++) begin
            for (int k = 0; k < D; k++) begin
                if ($urandom_range(0, 9) == 0) b[k*4 +: 4] = 4'($urandom_range(0, 15));
                else                           b[k*4 +: 4] = 4'($urandom_range(0, 9));
            end
            run_conv(b, "random", got);
        end

        // Abort during division: outputs clear, no done, next conversion clean.
        run_conv(28'h5000000, "pre_abort", got);
        @(negedge CLK);
        bus.i_ce  = 1'b1;
        bus.i_bcd = 28'h2500000;
        @(posedge CLK);
        #1;
        bus.i_ce = 1'b0;
        repeat (D + 3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_val("abort/bin", 64'(bus.o_bin), 64'd0);
        check_val("abort/done", 64'(bus.done), 64'd0);
        check_val("abort/err", 64'(bus.o_err), 64'd0);
        check_val("abort/busy", 64'(bus.o_busy), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        dn = 0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (bus.done) dn++;
        end
        check_val("abort/no_done", 64'(dn), 64'd0);
        run_conv(28'h1000000, "post_abort", got);
        check_val("post_abort_c", 64'(got), 64'h1A);

        // i_ce held high: one result every D+F+2 cycles.
        @(negedge CLK);
        bus.i_ce  = 1'b1;
        bus.i_bcd = 28'h1000000;
        @(posedge CLK);
        cyc = 0;
        while (cyc < 90) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (bus.done) begin
                t_done.push_back(cyc);
                check_val("stream/bin", 64'(bus.o_bin), 64'h1A);
            end
        end
        bus.i_ce = 1'b0;
        check_val("stream/count", 64'(t_done.size()), 64'd5);
        if (t_done.size() > 0) check_val("stream/first", 64'(t_done[0]), 64'(LAT));
        for (int i = 1; i < t_done.size(); i++)
            check_val("stream/period", 64'(t_done[i] - t_done[i-1]), 64'(LAT + 1));
        repeat (3) @(posedge CLK);
        #1;
        wait_idle();
        @(posedge CLK);
        #1;

        // i_ce pulses while busy are ignored.
        @(negedge CLK);
        bus.i_ce  = 1'b1;
        bus.i_bcd = 28'h2500000;
        @(posedge CLK);
        #1;
        bus.i_ce = 1'b0;
        dn  = 0;
        cyc = 0;
        for (int k = 1; k <= LAT + 25; k++) begin
            @(posedge CLK);
            #1;
            if (bus.done) begin
                dn++;
                cyc = k;
                check_val("busy_ce/bin", 64'(bus.o_bin), 64'h40);
            end
            if (k < LAT) begin
                bus.i_ce  = 1'($urandom_range(0, 1));
                bus.i_bcd = 28'h9000000;
            end else begin
                bus.i_ce = 1'b0;
            end
        end
        check_val("busy_ce/count", 64'(dn), 64'd1);
        check_val("busy_ce/latency", 64'(cyc), 64'(LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/bcd_frac_to_bin.md
BCD_FRAC_TO_BIN -- requirements
Module: bcd_frac_to_bin

Interface
REQ-001 Parameter FRACTIONAL_BITS, default 8, sets the width F of the binary fraction output.
REQ-002 Parameter DECIMAL_DIGITS, default 7, sets the number D of BCD fractional digits in.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 i_ce  input  1  start strobe; sampled only in IDLE.
REQ-006 i_bcd  input  D*4  BCD fraction; nibble [D*4-1 -: 4] is the tenths digit, nibble [3:0] is the 10^-D digit.
REQ-007 o_bin  output  F  binary fraction result, value = o_bin / 2^F.
REQ-008 done  output  1  one-cycle pulse: o_bin and o_err are valid.
REQ-009 o_err  output  1  set with done when any input nibble exceeded 9.
REQ-010 o_busy  output  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, ACCUM, DIV and ROUND, with no other reachable state; an illegal encoding SHALL return to IDLE on the next edge.
REQ-012 In IDLE with i_ce=1, the block SHALL capture i_bcd, clear the accumulator N, error flag and digit counter, and go to ACCUM; i_bcd is not sampled again.
REQ-013 In IDLE with i_ce=0, the block SHALL hold all outputs except done, which SHALL be 0.
REQ-014 ACCUM SHALL take exactly D cycles, one digit per cycle, MSD first: N <= N*10 + digit.
REQ-015 The N register SHALL be at least ceil(log2(10^D)) bits wide (24 bits for D=7) and SHALL never overflow.
REQ-016 A digit >9 SHALL set the sticky error flag, and 0 SHALL be added for that digit; accumulation continues.
REQ-017 After the D-th ACCUM cycle, the FSM SHALL go to DIV with remainder R <= N and quotient Q <= 0.
REQ-018 DIV SHALL take exactly F cycles of restoring fractional division by 10^D, MSB first. Each cycle: R2 = 2R; if R2 >= 10^D then shift a 1 into Q and R <= R2 - 10^D, else shift a 0 into Q and R <= R2.
REQ-019 R and R2 SHALL be one bit wider than N so that 2R does not overflow.
REQ-020 In ROUND, if 2R >= 10^D (round half up), the result SHALL be Q+1, otherwise Q.
REQ-021 If Q+1 = 2^F, the result SHALL saturate to 2^F-1.
REQ-022 If the error flag is set, ROUND SHALL force o_bin to 0.
REQ-023 ROUND SHALL register o_bin and o_err, set done=1, and return to IDLE.
REQ-024 Latency: with i_ce sampled at edge 0, done SHALL be high during the cycle after edge D+F+1 (16 for defaults), for exactly one cycle.
REQ-025 i_ce while o_busy=1 SHALL be ignored, with no queuing.
REQ-026 i_ce high in the IDLE cycle in which done is high SHALL start a new conversion, so back-to-back throughput is one result per D+F+2 cycles.
REQ-027 o_bin and o_err SHALL hold their last values until the next ROUND.
REQ-028 D or F changes SHALL only resize registers and counters; all 10^D constants SHALL be computed from the parameter.

Reset
REQ-029 While RST=1, the state SHALL be IDLE and o_bin, done, o_err, o_busy, N, R, Q and the counter SHALL all be 0.
REQ-030 RST asserted mid-conversion (any state) SHALL abort it with no done pulse; the first i_ce after release SHALL start a clean conversion.

Verification
REQ-031 i_bcd=0x5000000 (0.5) -> done at edge 16, o_bin=0x80, o_err=0.
REQ-032 i_bcd=0x1000000 (0.1 = 25.6/256) -> o_bin=0x1A (rounded up). i_bcd=0x2500000 -> o_bin=0x40.
REQ-033 i_bcd=0x0039062 -> o_bin=0x01 (0.99999 rounded up). i_bcd=0x9999999 -> o_bin=0xFF (saturated). i_bcd=0 -> o_bin=0x00.
REQ-034 i_bcd=0x3A00000 (invalid nibble) -> done with o_err=1, o_bin=0x00. The next valid conversion -> o_err=0.
REQ-035 Exhaustive round trip: for every 8-bit x, feed the 7-digit truncated decimal expansion of x/256 -> o_bin=x.
REQ-036 Disturbance checks:
- RST pulse during DIV -> all outputs 0, no done.
- i_ce held high throughout -> exactly one done every 17 cycles.
- i_ce pulses while busy -> no effect.
